div_step_sequencer: RTL

DIV_STEP_SEQUENCER -- requirements
Module: div_step_sequencer

---
 rtl/div_step_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/div_step_sequencer.sv
// ============================================================================
// Module   : div_step_sequencer
// Brief    : Steps a clock divider through a programmable table of divisors,
//            holding each divisor for a programmed number of divider ticks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step_sequencer #(
    parameter int DEPTH   = 8,
    parameter int DIV_W   = 26,
    parameter int RST_DIV = 59999999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [7:0]       cfg_reps,
    input  logic [2:0]       seq_last,
    input  logic             loop_en,
    input  logic             start,
    input  logic             stop,
    input  logic             tick_in,
    output logic [DIV_W-1:0] div_out,
    output logic             div_load,
    output logic             busy,
    output logic [2:0]       step_idx,
    output logic             done,
    output logic             cfg_err
);

    localparam logic [DIV_W-1:0] c_RST_DIV  = DIV_W'(RST_DIV);
    localparam logic [2:0]       c_LAST_MAX = 3'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_idx, w_idx_nxt;
    logic [2:0]       r_last, w_last_nxt, w_last_clamped;
    logic [7:0]       r_rep_cnt, w_rep_nxt;
    logic             w_done_nxt, w_load_nxt, w_wr_en;
    logic [DIV_W-1:0] w_div_sel;
    logic [DIV_W-1:0] r_div_out;
    logic             r_div_load, r_done, r_cfg_err;

    logic [DIV_W-1:0] r_tbl_div  [DEPTH];
    logic [7:0]       r_tbl_reps [DEPTH];

    generate
        if (DEPTH < 8) begin : g_clamp
            assign w_last_clamped = (seq_last > c_LAST_MAX) ? c_LAST_MAX : seq_last;
        end else begin : g_noclamp
            assign w_last_clamped = seq_last;
        end
    endgenerate

    assign w_wr_en = cfg_we && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_tbl_div[i]  <= c_RST_DIV;
                r_tbl_reps[i] <= 8'd0;
            end
        end else if (w_wr_en) begin
            r_tbl_div[cfg_addr]  <= cfg_div;
            r_tbl_reps[cfg_addr] <= cfg_reps;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_rep_nxt   = r_rep_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = S_LOAD;
                    w_idx_nxt   = 3'd0;
                    w_last_nxt  = w_last_clamped;
                end
            end
            S_LOAD: begin
                w_rep_nxt = 8'd0;
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (tick_in) begin
                    if (r_rep_cnt != r_tbl_reps[r_idx]) begin
                        w_rep_nxt = r_rep_cnt + 8'd1;
                    end else if (r_idx != r_last) begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = S_LOAD;
                    end else if (loop_en) begin
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_LOAD;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_load_nxt = (w_state_nxt == S_LOAD);

    // Bypass lets a start see an entry written on the same edge.
    assign w_div_sel = (w_wr_en && (cfg_addr == w_idx_nxt)) ? cfg_div : r_tbl_div[w_idx_nxt];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= 3'd0;
            r_last     <= 3'd0;
            r_rep_cnt  <= 8'd0;
            r_div_out  <= c_RST_DIV;
            r_div_load <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_idx      <= w_idx_nxt;
            r_last     <= w_last_nxt;
            r_rep_cnt  <= w_rep_nxt;
            r_div_load <= w_load_nxt;
            r_done     <= w_done_nxt;
            r_cfg_err  <= cfg_we && (r_state != S_IDLE);
            if (w_load_nxt) begin
                r_div_out <= w_div_sel;
            end
        end
    end

    assign div_out  = r_div_out;
    assign div_load = r_div_load;
    assign busy     = (r_state != S_IDLE);
    assign step_idx = r_idx;
    assign done     = r_done;
    assign cfg_err  = r_cfg_err;

endmodule

`default_nettype wire
